// File: rtl/led_seq_pkg.sv
// Shared constants and types for the LED pattern sequencer: register map,
// CTRL/STATUS bit positions, FSM state encoding and slot count.
package led_seq_pkg;

  localparam int NUM_SLOTS = 4;

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_STATUS = 3'd1;
  localparam logic [2:0] ADDR_DWELL  = 3'd2;
  localparam logic [2:0] ADDR_MANUAL = 3'd3;

  localparam int CTRL_RUN      = 0;
  localparam int CTRL_LOOP     = 1;
  localparam int CTRL_LAST_LSB = 2;
  localparam int CTRL_IRQ_EN   = 4;

  localparam int STATUS_BUSY    = 0;
  localparam int STATUS_CUR_LSB = 1;
  localparam int STATUS_DONE    = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Word addresses 4..7 are the four pattern slots.
  function automatic logic is_slot_addr(input logic [2:0] addr);
    return addr[2];
  endfunction

endpackage

// File: rtl/led_seq_dwell_timer.sv
// Down-counter that measures how long the current slot stays on the LEDs;
// tc flags a count of zero and the counter holds there until reloaded.
module led_seq_dwell_timer #(
  parameter int DWELL_W = 24
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_val,
  input  logic               en,
  output logic               tc
);

  logic [DWELL_W-1:0] count_q;
  logic [DWELL_W-1:0] count_d;

  assign tc = (count_q == {DWELL_W{1'b0}});

  // Next count: load has priority, otherwise count down and stop at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && !tc) begin
      count_d = count_q - {{(DWELL_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= {DWELL_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/nios_system_led_sequencer.sv
// Avalon-MM LED driver: static MANUAL value or autonomous stepping through up
// to four patterns. Optional interrupt enable is built when LED_SEQ_IRQ_EN is defined.
module nios_system_led_sequencer
  import led_seq_pkg::*;
#(
  parameter int DWELL_W = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  out_port,
  output logic        irq
);

  state_e             state_q, state_d;
  logic [1:0]         cur_q, cur_d;
  logic               done_q, done_d;
  logic [7:0]         out_port_q, out_port_d;
  logic               irq_q, irq_d;

  logic               loop_q;
  logic [1:0]         last_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [7:0]         manual_q;
  logic [7:0]         slot_q [NUM_SLOTS];
  logic               irq_en_s;
  logic               irq_en_d;

  logic               wr_s;
  logic               ctrl_wr_s;
  logic               status_wr_s;
  logic               start_s;
  logic               stop_s;
  logic               timer_load_s;
  logic               timer_en_s;
  logic               tc_s;
  logic               done_set_s;
  logic [DWELL_W-1:0] reload_val_s;
  logic [31:0]        rd_s;
  logic               unused_wdata_s;

  assign wr_s        = chipselect && !write_n;
  assign ctrl_wr_s   = wr_s && (address == ADDR_CTRL);
  assign status_wr_s = wr_s && (address == ADDR_STATUS);
  assign start_s     = ctrl_wr_s && writedata[CTRL_RUN];
  assign stop_s      = ctrl_wr_s && !writedata[CTRL_RUN];
  assign timer_en_s  = (state_q == ST_RUN);
  // DWELL of 0 behaves as 1, so the reload value saturates at 0.
  assign reload_val_s = (dwell_q == {DWELL_W{1'b0}}) ? {DWELL_W{1'b0}}
                                                     : dwell_q - {{(DWELL_W-1){1'b0}}, 1'b1};
  assign unused_wdata_s = &{1'b0, writedata};

  led_seq_dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_dwell_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (timer_load_s),
    .load_val (reload_val_s),
    .en       (timer_en_s),
    .tc       (tc_s)
  );

`ifdef LED_SEQ_IRQ_EN
  logic irq_en_q;

  assign irq_en_d = ctrl_wr_s ? writedata[CTRL_IRQ_EN] : irq_en_q;
  assign irq_en_s = irq_en_q;

  // Interrupt enable bit of CTRL.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en_q <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
    end
  end
`else
  assign irq_en_d = 1'b0;
  assign irq_en_s = 1'b0;
`endif

  // Software-writable configuration and pattern registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      loop_q   <= 1'b0;
      last_q   <= 2'd0;
      dwell_q  <= {DWELL_W{1'b0}};
      manual_q <= 8'd0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_q[i] <= 8'd0;
      end
    end else if (wr_s) begin
      if (is_slot_addr(address)) begin
        slot_q[address[1:0]] <= writedata[7:0];
      end else begin
        case (address)
          ADDR_CTRL: begin
            loop_q <= writedata[CTRL_LOOP];
            last_q <= writedata[CTRL_LAST_LSB +: 2];
          end
          ADDR_DWELL:  dwell_q  <= writedata[DWELL_W-1:0];
          ADDR_MANUAL: manual_q <= writedata[7:0];
          default: ;
        endcase
      end
    end
  end

  // Sequencer next state: start/restart, stop, slot advance, wrap or finish.
  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    timer_load_s = 1'b0;
    done_set_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          state_d      = ST_RUN;
          cur_d        = 2'd0;
          timer_load_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (start_s) begin
          cur_d        = 2'd0;
          timer_load_s = 1'b1;
        end else if (stop_s) begin
          state_d = ST_IDLE;
          cur_d   = 2'd0;
        end else if (tc_s) begin
          if (cur_q != last_q) begin
            cur_d        = cur_q + 2'd1;
            timer_load_s = 1'b1;
          end else if (loop_q) begin
            cur_d        = 2'd0;
            timer_load_s = 1'b1;
          end else begin
            state_d    = ST_IDLE;
            cur_d      = 2'd0;
            done_set_s = 1'b1;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cur_d   = 2'd0;
      end
    endcase
  end

  // DONE is sticky; a hardware set outranks a software clear in the same cycle.
  always_comb begin
    done_d = done_q;
    if (done_set_s) begin
      done_d = 1'b1;
    end else if (status_wr_s && writedata[STATUS_DONE]) begin
      done_d = 1'b0;
    end else begin
      done_d = done_q;
    end
  end

  assign out_port_d = (state_d == ST_RUN) ? slot_q[cur_d] : manual_q;
  assign irq_d      = done_d && irq_en_d;

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cur_q      <= 2'd0;
      done_q     <= 1'b0;
      out_port_q <= 8'd0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      done_q     <= done_d;
      out_port_q <= out_port_d;
      irq_q      <= irq_d;
    end
  end

  // Zero-latency read mux; unused bits read as zero.
  always_comb begin
    rd_s = 32'd0;
    case (address)
      ADDR_CTRL: begin
        rd_s[CTRL_RUN]             = (state_q == ST_RUN);
        rd_s[CTRL_LOOP]            = loop_q;
        rd_s[CTRL_LAST_LSB +: 2]   = last_q;
        rd_s[CTRL_IRQ_EN]          = irq_en_s;
      end
      ADDR_STATUS: begin
        rd_s[STATUS_BUSY]          = (state_q == ST_RUN);
        rd_s[STATUS_CUR_LSB +: 2]  = cur_q;
        rd_s[STATUS_DONE]          = done_q;
      end
      ADDR_DWELL:  rd_s[DWELL_W-1:0] = dwell_q;
      ADDR_MANUAL: rd_s[7:0]         = manual_q;
      3'd4, 3'd5, 3'd6, 3'd7: rd_s[7:0] = slot_q[address[1:0]];
      default: rd_s = 32'd0;
    endcase
  end

  assign readdata = rd_s;
  assign out_port = out_port_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_nios_system_led_sequencer.sv
// Self-checking bench for nios_system_led_sequencer: register table, directed
// sequences and randomized runs against an arithmetic timeline model.
module tb_nios_system_led_sequencer;

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_STATUS = 3'd1;
  localparam logic [2:0] A_DWELL  = 3'd2;
  localparam logic [2:0] A_MANUAL = 3'd3;
`ifdef LED_SEQ_IRQ_EN
  localparam bit IRQ_IMPL = 1'b1;
`else
  localparam bit IRQ_IMPL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;
  logic        irq;

  int passed = 0;
  int total  = 0;
  logic [7:0] slots_m [4];
  logic [7:0] manual_m;

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } reg_vec_t;
  reg_vec_t vecs [7];

  nios_system_led_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1;
    #1;
    d = readdata;
    chipselect = 1'b0;
  endtask

  task automatic load_regs(input logic [7:0] s0, input logic [7:0] s1,
                           input logic [7:0] s2, input logic [7:0] s3, input logic [7:0] man);
    slots_m[0] = s0; slots_m[1] = s1; slots_m[2] = s2; slots_m[3] = s3; manual_m = man;
    for (int i = 0; i < 4; i++) bus_write(3'(4 + i), {24'd0, slots_m[i]});
    bus_write(A_MANUAL, {24'd0, man});
    bus_write(A_STATUS, 32'h8);
  endtask

  // Start a run and compare every cycle against the expected timeline:
  // slot k/d (mod LAST+1 when looping), then MANUAL with DONE after (LAST+1)*d.
  task automatic run_seq(input int dwell, input int last, input bit loop, input bit ien, input int ncycles);
    int d;
    int slot;
    logic [31:0] rd;
    logic [7:0] exp_out;
    logic [3:0] exp_st;
    logic exp_irq;
    d = (dwell == 0) ? 1 : dwell;
    bus_write(A_DWELL, 32'(dwell));
    bus_write(A_CTRL, 32'(1) | (32'(loop) << 1) | (32'(last) << 2) | (32'(ien) << 4));
    for (int k = 0; k <= ncycles; k++) begin
      if (k > 0) cycle();
      if (!loop && k >= (last + 1) * d) begin
        exp_out = manual_m; exp_st = 4'b1000; exp_irq = IRQ_IMPL && ien;
      end else begin
        slot = (k / d) % (last + 1);
        exp_out = slots_m[slot]; exp_st = {1'b0, 2'(slot), 1'b1}; exp_irq = 1'b0;
      end
      chk("seq_out", {24'd0, out_port}, {24'd0, exp_out});
      bus_read(A_STATUS, rd);
      chk("seq_status", rd, {28'd0, exp_st});
      chk("seq_irq", {31'd0, irq}, {31'd0, exp_irq});
    end
    if (loop) begin
      bus_write(A_CTRL, 32'(0) | (32'(loop) << 1) | (32'(last) << 2));
      chk("stop_out", {24'd0, out_port}, {24'd0, manual_m});
      bus_read(A_STATUS, rd);
      chk("stop_status", rd, 32'd0);
    end
  endtask

  initial begin
    logic [31:0] rd;
    int dw, lst, ncyc;
    bit lp;

    reset_n = 1'b0; address = 3'd0; chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out", {24'd0, out_port}, 32'd0);
    chk("reset_irq", {31'd0, irq}, 32'd0);
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), rd);
      chk("reset_read", rd, 32'd0);
    end
    reset_n = 1'b1;

    bus_write(A_MANUAL, 32'hA5);
    chk("manual_not_yet", {24'd0, out_port}, 32'h00);
    cycle();
    chk("manual_out", {24'd0, out_port}, 32'hA5);

    vecs[0] = '{A_DWELL,  32'h00123456, 32'h00123456};
    vecs[1] = '{A_DWELL,  32'hFFFFFFFF, 32'h00FFFFFF};
    vecs[2] = '{A_MANUAL, 32'h000001FF, 32'h000000FF};
    vecs[3] = '{3'd4,     32'hDEADBEEF, 32'h000000EF};
    vecs[4] = '{3'd7,     32'h12345680, 32'h00000080};
    vecs[5] = '{A_CTRL,   32'h0000001E, IRQ_IMPL ? 32'h0000001E : 32'h0000000E};
    vecs[6] = '{A_STATUS, 32'h0000000F, 32'h00000000};
    for (int i = 0; i < 7; i++) begin
      bus_write(vecs[i].addr, vecs[i].wdata);
      bus_read(vecs[i].addr, rd);
      chk("reg_table", rd, vecs[i].exp);
    end

    // One-shot, loop-then-stop, DWELL=0.
    load_regs(8'h01, 8'h02, 8'h04, 8'h08, 8'hA5);
    run_seq(3, 3, 1'b0, 1'b0, 14);
    load_regs(8'h01, 8'h02, 8'h04, 8'h08, 8'h3C);
    run_seq(2, 1, 1'b1, 1'b0, 9);
    load_regs(8'h11, 8'h22, 8'h44, 8'h88, 8'h5A);
    run_seq(0, 2, 1'b0, 1'b0, 5);

    // Interrupt rise with DONE, clear, and set/clear collision.
    load_regs(8'h81, 8'h42, 8'h24, 8'h18, 8'h99);
    run_seq(2, 0, 1'b0, 1'b1, 4);
    bus_write(A_STATUS, 32'h8);
    chk("irq_cleared", {31'd0, irq}, 32'd0);
    bus_write(A_DWELL, 32'd1);
    bus_write(A_CTRL, 32'h11);
    bus_write(A_STATUS, 32'h8);
    chk("collide_irq", {31'd0, irq}, {31'd0, IRQ_IMPL});
    bus_read(A_STATUS, rd);
    chk("collide_done", rd, 32'h8);
    bus_write(A_STATUS, 32'h8);
    bus_read(A_STATUS, rd);
    chk("done_cleared", rd, 32'h0);

    // Randomized runs.
    for (int t = 0; t < 8; t++) begin
      load_regs(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      dw = $urandom_range(0, 4);
      lst = $urandom_range(0, 3);
      lp = 1'($urandom_range(0, 1));
      ncyc = lp ? $urandom_range(3, 20) : (lst + 1) * ((dw == 0) ? 1 : dw) + 2;
      run_seq(dw, lst, lp, 1'b0, ncyc);
    end

    // Restart during slot 2, then asynchronous reset mid-run.
    load_regs(8'h0F, 8'hF0, 8'h3C, 8'hC3, 8'h77);
    bus_write(A_DWELL, 32'd3);
    bus_write(A_CTRL, 32'h0D);
    repeat (6) cycle();
    chk("pre_restart", {24'd0, out_port}, {24'd0, slots_m[2]});
    bus_write(A_CTRL, 32'h0D);
    chk("restart_out", {24'd0, out_port}, {24'd0, slots_m[0]});
    bus_read(A_STATUS, rd);
    chk("restart_status", rd, 32'h1);
    cycle();
    #1;
    reset_n = 1'b0;
    #1;
    chk("areset_out", {24'd0, out_port}, 32'd0);
    bus_read(A_STATUS, rd);
    chk("areset_status", rd, 32'd0);
    bus_read(A_MANUAL, rd);
    chk("areset_manual", rd, 32'd0);
    #1;
    reset_n = 1'b1;
    cycle();
    chk("post_reset_out", {24'd0, out_port}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
